div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  RISC-V M-extension divide sequencer placed between the execute stage and the iterative unsigned
//  divider. Decodes DIV/DIVU/REM/REMU, converts signed operands to magnitudes, launches the
//  divider, applies sign correction and returns one result per request over a valid/ready pair.
//  Resolves divide-by-zero and signed overflow locally per the RISC-V spec, without the divider.
// PARAMETERS
//  XLEN      32  operand/result width; must equal the divider WIDTH
//  TAG_W     5   destination-register tag width, passed through unchanged
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset_n    in   1      asynchronous active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      sequencer accepts request this cycle
//  req_op     in   2      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  req_a      in   XLEN   rs1 (dividend)
//  req_b      in   XLEN   rs2 (divisor)
//  req_tag    in   TAG_W  destination tag
//  flush      in   1      kill in-flight request; no result produced
//  res_valid  out  1      result present
//  res_ready  in   1      consumer accepts result
//  res_data   out  XLEN   quotient or remainder
//  res_tag    out  TAG_W  tag of the request
//  div_start  out  1      divider start; high exactly one clk cycle per launch
//  div_x      out  XLEN   unsigned dividend magnitude
//  div_y      out  XLEN   unsigned divisor magnitude (never 0)
//  div_busy   in   1      divider busy (divider updates on negedge clk)
//  div_done   in   1      divider finished
//  div_q      in   XLEN   unsigned quotient
//  div_r      in   XLEN   unsigned remainder
// BEHAVIOUR
//  Reset: state IDLE; req_ready=0 until div_busy=0; res_valid=0, div_start=0; res_data, res_tag, div_x, div_y = 0.
//  States: IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN.
//  req_ready = (state==IDLE) & ~div_busy. Accept on req_valid & req_ready: latch op, a, b, tag.
//  IDLE->RESP directly (no divider launch) when:
//   b==0: quotient = all ones, remainder = a.
//   signed op, a==2^(XLEN-1), b==all ones: quotient = a, remainder = 0.
//  Otherwise IDLE->LAUNCH: div_x=|a|, div_y=|b| (signed ops use two's-complement magnitude,
//   unsigned ops pass raw); div_start=1 for this cycle only; LAUNCH->WAIT next cycle.
//  WAIT: leave on div_done & ~div_busy -> FIX. Divider valid is ignored.
//  FIX: one cycle; capture q/r; signed ops: negate q iff sign(a)^sign(b), negate r iff sign(a);
//   select q (DIV/DIVU) or r (REM/REMU) into res_data -> RESP.
//  RESP: res_valid=1, res_data/res_tag held stable until res_valid & res_ready -> IDLE.
//  Latency (divider path, res_ready=1): accept to res_valid = XLEN+3 cycles; fast path: 1 cycle.
//  flush: in LAUNCH or WAIT -> DRAIN; in RESP -> IDLE, res_valid drops next cycle; in IDLE/FIX the
//   latched request is discarded (FIX->IDLE). flush with req_valid same cycle: request not accepted.
//  DRAIN: wait div_done & ~div_busy, discard q/r, -> IDLE. Divider has no abort.
//  Reset mid-operation: FSM returns to IDLE; req_ready stays 0 while divider still busy.
//  Only one request in flight; no back-to-back overlap; sign rules exact for all XLEN values.
// TESTING
//  DIV a=-7, b=2 -> res_data=-3 (0xFFFFFFFD); REM same operands -> -1 (0xFFFFFFFF).
//  DIVU a=0xFFFFFFFF, b=16 -> 0x0FFFFFFF; REMU -> 0xF; div_start pulses once.
//  DIV a=5, b=0 -> 0xFFFFFFFF one cycle after accept, div_start never asserted; REM -> 5.
//  DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; no divider launch.
//  flush 4 cycles after launch -> no res_valid; req_ready=0 until div_done; next DIVU 9/3 -> 3.
//  res_ready low 5 cycles in RESP -> res_data/res_tag stable; reset_n low mid-WAIT -> outputs reset values.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: RISC-V DIV/DIVU/REM/REMU sequencer around an unsigned divider.
// Resolves divide-by-zero and signed overflow locally and fixes result signs.
module div_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             div_start,
    output logic [XLEN-1:0]  div_x,
    output logic [XLEN-1:0]  div_y,
    input  logic             div_busy,
    input  logic             div_done,
    input  logic [XLEN-1:0]  div_q,
    input  logic [XLEN-1:0]  div_r
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FIX,
        RESP,
        DRAIN
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nxt;

    logic [1:0]      op_q;
    logic            sa_q;
    logic            sb_q;
    logic            accept;
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic            ovf;
    logic            fast;
    logic            div_ok;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] fast_res;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_res;

    assign req_ready = (state == IDLE) & ~div_busy;
    assign accept    = req_valid & req_ready & ~flush;

    // op[0] clear means signed (DIV/REM)
    assign is_signed = ~req_op[0];
    assign a_neg     = is_signed & req_a[XLEN-1];
    assign b_neg     = is_signed & req_b[XLEN-1];
    assign a_mag     = a_neg ? -req_a : req_a;
    assign b_mag     = b_neg ? -req_b : req_b;

    assign b_zero = ~|req_b;
    assign ovf    = is_signed & (req_a == MIN_NEG) & (&req_b);
    assign fast   = b_zero | ovf;

    always_comb begin
        fast_res = '0;
        if (b_zero) begin
            fast_res = req_op[1] ? req_a : '1;
        end else if (ovf) begin
            fast_res = req_op[1] ? '0 : req_a;
        end
    end

    assign div_ok  = div_done & ~div_busy;
    assign q_fix   = (sa_q ^ sb_q) ? -div_q : div_q;
    assign r_fix   = sa_q ? -div_r : div_r;
    assign fix_res = op_q[1] ? r_fix : q_fix;

    always_comb begin
        state_nxt = state;
        res_valid = 1'b0;
        div_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = fast ? RESP : LAUNCH;
                end
            end
            LAUNCH: begin
                div_start = 1'b1;
                state_nxt = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                // divider has no abort, so a flush must outlive it
                if (flush) begin
                    state_nxt = div_ok ? IDLE : DRAIN;
                end else if (div_ok) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = flush ? IDLE : RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (flush || res_ready) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (div_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div_x    <= '0;
            div_y    <= '0;
            res_data <= '0;
            res_tag  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= req_op;
                sa_q    <= a_neg;
                sb_q    <= b_neg;
                res_tag <= req_tag;
                if (fast) begin
                    res_data <= fast_res;
                end else begin
                    div_x <= a_mag;
                    div_y <= b_mag;
                end
            end
            if (state == FIX) begin
                res_data <= fix_res;
            end
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: randomized and directed bench for div_seq_ctrl.
// Uses a negedge behavioural divider and a plain-arithmetic result model.
module tb_div_seq_ctrl;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [XLEN-1:0]  req_a = '0;
    logic [XLEN-1:0]  req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [XLEN-1:0]  res_data;
    logic [TAG_W-1:0] res_tag;
    logic             div_start;
    logic [XLEN-1:0]  div_x;
    logic [XLEN-1:0]  div_y;
    logic             div_busy = 1'b0;
    logic             div_done = 1'b0;
    logic [XLEN-1:0]  div_q = '0;
    logic [XLEN-1:0]  div_r = '0;

    logic [XLEN-1:0]  dx = '0;
    logic [XLEN-1:0]  dy = '0;
    int               dcnt = 0;

    int n_chk = 0;
    int n_pass = 0;

    div_seq_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .div_start (div_start),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r)
    );

    always #5 clk = ~clk;

    // iterative divider: XLEN negedges of work after the start negedge
    always @(negedge clk) begin
        if (div_start) begin
            div_busy <= 1'b1;
            div_done <= 1'b0;
            dcnt     <= XLEN;
            dx       <= div_x;
            dy       <= div_y;
        end else if (div_busy) begin
            if (dcnt == 1) begin
                div_busy <= 1'b0;
                div_done <= 1'b1;
                div_q    <= (dy == 0) ? '1 : dx / dy;
                div_r    <= (dy == 0) ? dx : dx % dy;
            end else begin
                dcnt <= dcnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        ua = longint'(a);
        ub = longint'(b);
        return op[1] ? 32'(ua % ub) : 32'(ua / ub);
    endfunction

    function automatic logic [31:0] mag(input logic [1:0] op,
                                        input logic [31:0] v);
        return (!op[0] && v[31]) ? -v : v;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready();
        int cyc = 0;
        while (!req_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ready", 32'(req_ready), 32'd1);
    endtask

    task automatic accept_req(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] tag);
        wait_ready();
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input int hold);
        logic [31:0] exp;
        bit          fast;
        int          cyc;
        int          starts;
        exp  = ref_div(op, a, b);
        fast = (b == 0) || (!op[0] && a == MIN && b == 32'hFFFF_FFFF);
        res_ready = (hold == 0);
        accept_req(op, a, b, tag);
        cyc    = 1;
        starts = 0;
        while (!res_valid && cyc < 200) begin
            if (div_start) begin
                starts++;
                check("div_x", div_x, mag(op, a));
                check("div_y", div_y, mag(op, b));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("res_valid", 32'(res_valid), 32'd1);
        check("latency", 32'(cyc), fast ? 32'd1 : 32'(XLEN + 3));
        check("starts", 32'(starts), fast ? 32'd0 : 32'd1);
        check("res_data", res_data, exp);
        check("res_tag", 32'(res_tag), 32'(tag));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", res_data, exp);
            check("hold_tag", 32'(res_tag), 32'(tag));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("res_drop", 32'(res_valid), 32'd0);
    endtask

    task automatic flush_test(input int delay);
        int cyc = 0;
        bit seen = 1'b0;
        accept_req(2'b01, 32'd1000, 32'd7, 5'd3);
        repeat (delay) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready_low", 32'(req_ready), 32'd0);
        while (!req_ready && cyc < 100) begin
            seen |= res_valid;
            @(posedge clk); #1;
            cyc++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        check("flush_done", 32'(div_done), 32'd1);
        do_req(2'b01, 32'd9, 32'd3, 5'd7, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_start", 32'(div_start), 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_tag", 32'(res_tag), 32'd0);
        check("rst_x", div_x, 32'd0);
        check("rst_y", div_y, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_req(2'b00, -32'd7, 32'd2, 5'd1, 0);
        do_req(2'b10, -32'd7, 32'd2, 5'd2, 0);
        do_req(2'b01, 32'hFFFF_FFFF, 32'd16, 5'd3, 0);
        do_req(2'b11, 32'hFFFF_FFFF, 32'd16, 5'd4, 0);
        do_req(2'b00, 32'd5, 32'd0, 5'd5, 0);
        do_req(2'b10, 32'd5, 32'd0, 5'd6, 0);
        do_req(2'b00, MIN, 32'hFFFF_FFFF, 5'd7, 0);
        do_req(2'b10, MIN, 32'hFFFF_FFFF, 5'd8, 0);
        do_req(2'b01, MIN, 32'hFFFF_FFFF, 5'd9, 0);
        do_req(2'b00, 32'd100, -32'd9, 5'd10, 5);

        flush_test(4);
        flush_test(0);

        // flush while a result waits
        res_ready = 1'b0;
        accept_req(2'b00, 32'd5, 32'd0, 5'd11);
        check("rflush_valid", 32'(res_valid), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        res_ready = 1'b1;
        check("rflush_drop", 32'(res_valid), 32'd0);

        // flush with req_valid in the same cycle
        wait_ready();
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'd50;
        req_b     = 32'd5;
        flush     = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("fv_start", 32'(div_start), 32'd0);
        check("fv_ready", 32'(req_ready), 32'd1);

        // reset in the middle of a divide
        do_req(2'b01, 32'd77, 32'd7, 5'd12, 0);
        accept_req(2'b01, 32'd1000, 32'd3, 5'd13);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mrst_valid", 32'(res_valid), 32'd0);
        check("mrst_start", 32'(div_start), 32'd0);
        check("mrst_data", res_data, 32'd0);
        check("mrst_tag", 32'(res_tag), 32'd0);
        check("mrst_x", div_x, 32'd0);
        check("mrst_y", div_y, 32'd0);
        check("mrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_ready();
        check("mrst_busy", 32'(div_busy), 32'd0);
        check("mrst_novalid", 32'(res_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            do_req(2'($urandom_range(0, 3)), pick(), pick(),
                   5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
